fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, upstream of the hazard unit.
- Owns PCF and issues requests to a variable-latency instruction memory using a req/ready handshake.
- Applies StallF, StallD and decode-stage redirects (PCSrcD/JumpD), and inserts the IF/ID NOP on redirect; the hazard unit only flushes ID/EX.
- Delivers InstrD/PCPlus4D/ValidD to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on flush or bubble.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- StallF  input  1  hold PCF (hazard unit)
- StallD  input  1  hold IF/ID register (hazard unit)
- PCSrcD  input  1  branch taken in decode
- JumpD  input  1  jump in decode
- PCBranchD  input  32  branch target
- PCJumpD  input  32  jump target
- ImemReq  output  1  fetch request valid
- ImemAddr  output  32  fetch address; equals PCF
- ImemRdata  input  32  fetched word; valid when ImemReady=1
- ImemReady  input  1  completes the outstanding request this cycle
- PCF  output  32  current fetch PC
- InstrD  output  32  IF/ID instruction
- PCPlus4D  output  32  IF/ID PC+4
- ValidD  output  1  InstrD is a real instruction (0 = bubble)
- FetchBusy  output  1  request outstanding and not ready this cycle
- RedirectCount  output  32  performance counter (see optional feature)
- ImemWaitCount  output  32  performance counter (see optional feature)

Behaviour:
- Reset (async, rst_n=0): PCF=RESET_PC, ImemReq=0, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, FetchBusy=0, squash=0, buffer empty, state=IDLE, counters=0.
- FSM states: IDLE, FETCH, HOLD.
- IDLE: one cycle after reset release, then go to FETCH.
- FETCH:
  - ImemReq=1 and ImemAddr=PCF. Address stays stable until ImemReady.
  - FetchBusy = (state==FETCH) && !ImemReady.
- Redirect:
  - redir = (PCSrcD || JumpD) && !StallD.
  - Target is PCBranchD if PCSrcD, else PCJumpD (PCSrcD has priority).
  - Target bits [1:0] are forced to 00.
  - Redirects are ignored while StallD=1.
- Decode-register update when StallD=1: InstrD, PCPlus4D and ValidD hold, regardless of all other events.
- Decode-register update when StallD=0, in priority order:
  - redir: InstrD=NOP_INSTR, ValidD=0, PCPlus4D=0.
  - Delivering a word (FETCH with ImemReady and no squash, or HOLD exit): InstrD=word, PCPlus4D=fetch PC+4, ValidD=1.
  - Otherwise: bubble (InstrD=NOP_INSTR, ValidD=0).
- FETCH with ImemReady:
  - squash=1 or redir: discard the word, PCF<=redirect target (stored or current), clear squash, stay in FETCH (new request next cycle).
  - Else if StallF or StallD: store the word and its PC in the buffer, go to HOLD. PCF is held.
  - Else: deliver the word, PCF<=PCF+4, stay in FETCH.
- FETCH without ImemReady:
  - On redir, latch the target in RedirPC and set squash. PCF/ImemAddr stay unchanged until ready.
  - A second redir before ready overwrites RedirPC.
- HOLD:
  - ImemReq=0. InstrD holds while StallD=1.
  - On redir: discard the buffer, PCF<=target, go to FETCH.
  - When StallF=0 and StallD=0: deliver the buffer, PCF<=PCF+4, go to FETCH.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.
- Reset mid-request: the outstanding request is abandoned. After reset, a late ImemReady in IDLE is ignored.
- Single outstanding request only. The memory must not assert ImemReady while ImemReq=0; the block ignores it if it does.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - RedirectCount increments on every accepted redir.
  - ImemWaitCount increments every cycle FetchBusy=1.
  - Both are 32-bit wrapping counters, cleared by reset.
- Not defined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset release with ImemReady tied 1 and StallF/StallD=0 -> PCF follows 0, 4, 8, …; InstrD follows the memory words with 1-cycle IF/ID latency; ValidD=1 from the third cycle.
- ImemReady low 3 cycles at PCF=0x10 -> ImemAddr holds 0x10 and FetchBusy=1 for 3 cycles; ValidD=0 bubbles into D; the word is delivered when ready.
- PCSrcD=1, PCBranchD=0x100 with fetch ready -> next cycle InstrD=NOP_INSTR, ValidD=0, PCF=0x100; with FETCH_PERF_CNT_EN, RedirectCount=1.
- JumpD=1, PCJumpD=0x200 while the request at 0x40 is outstanding for 2 more cycles -> the 0x40 word is discarded; the next ImemAddr is 0x200.
- ImemReady=1 with StallF=StallD=1 for 2 cycles -> HOLD, InstrD/PCF unchanged; on release the buffered word appears in InstrD with ValidD=1.
- PCSrcD=1 with StallD=1 -> no redirect and D holds; PCF=0xFFFF_FFFC then +4 -> PCF=0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, variable-latency imem handshake and decode redirects.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic        JumpD,
    input  logic [31:0] PCBranchD,
    input  logic [31:0] PCJumpD,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRdata,
    input  logic        ImemReady,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusy,
    output logic [31:0] RedirectCount,
    output logic [31:0] ImemWaitCount
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state, state_nxt;
    logic        squash;
    logic [31:0] redir_pc;
    logic [31:0] buf_word;
    logic        redir;
    logic [31:0] redir_tgt;
    logic [31:0] pc_plus4;
    logic        stall_any;
    logic        deliver_fetch;
    logic        hold_exit;

    assign redir         = (PCSrcD || JumpD) && !StallD;
    assign redir_tgt     = (PCSrcD ? PCBranchD : PCJumpD) & 32'hFFFF_FFFC;
    assign pc_plus4      = PCF + 32'd4;
    assign stall_any     = StallF || StallD;
    assign deliver_fetch = (state == FETCH) && ImemReady && !squash && !redir && !stall_any;
    assign hold_exit     = (state == HOLD) && !redir && !stall_any;
    assign ImemAddr      = PCF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: if (ImemReady && !squash && !redir && stall_any) state_nxt = HOLD;
            HOLD:  if (redir || !stall_any) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ImemReq   = (state == FETCH);
        FetchBusy = (state == FETCH) && !ImemReady;
    end

    // PC only moves on a completed request or on leaving HOLD; an early redirect waits in redir_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PCF      <= RESET_PC;
            squash   <= 1'b0;
            redir_pc <= RESET_PC;
            buf_word <= NOP_INSTR;
        end else begin
            case (state)
                FETCH: begin
                    if (ImemReady) begin
                        if (redir) begin
                            PCF    <= redir_tgt;
                            squash <= 1'b0;
                        end else if (squash) begin
                            PCF    <= redir_pc;
                            squash <= 1'b0;
                        end else if (stall_any) begin
                            buf_word <= ImemRdata;
                        end else begin
                            PCF <= pc_plus4;
                        end
                    end else if (redir) begin
                        redir_pc <= redir_tgt;
                        squash   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redir)           PCF <= redir_tgt;
                    else if (!stall_any) PCF <= pc_plus4;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (deliver_fetch) begin
                InstrD   <= ImemRdata;
                PCPlus4D <= pc_plus4;
                ValidD   <= 1'b1;
            end else if (hold_exit) begin
                InstrD   <= buf_word;
                PCPlus4D <= pc_plus4;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= NOP_INSTR;
                PCPlus4D <= 32'd0;
                ValidD   <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RedirectCount <= 32'd0;
            ImemWaitCount <= 32'd0;
        end else begin
            if (redir)     RedirectCount <= RedirectCount + 32'd1;
            if (FetchBusy) ImemWaitCount <= ImemWaitCount + 32'd1;
        end
    end
`else
    assign RedirectCount = 32'd0;
    assign ImemWaitCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences (wrap, reset mid-request), random vs model.
module tb_fetch_stage;
    localparam logic [31:0] K   = 32'h5A5A_1234;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 0, StallD = 0, PCSrcD = 0, JumpD = 0, ImemReady = 0;
    logic [31:0] PCBranchD = 0, PCJumpD = 0;
    logic        ImemReq, ValidD, FetchBusy;
    logic [31:0] ImemAddr, ImemRdata, PCF, InstrD, PCPlus4D, RedirectCount, ImemWaitCount;

    int checks = 0;
    int failures = 0;

    // Memory content is a fixed function of the address.
    assign ImemRdata = ImemAddr ^ K;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
        .PCSrcD(PCSrcD), .JumpD(JumpD), .PCBranchD(PCBranchD), .PCJumpD(PCJumpD),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemRdata(ImemRdata), .ImemReady(ImemReady),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .FetchBusy(FetchBusy), .RedirectCount(RedirectCount), .ImemWaitCount(ImemWaitCount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sf, input logic sd, input logic br, input logic jp,
                         input logic [31:0] tb, input logic [31:0] tj, input logic rdy);
        StallF = sf; StallD = sd; PCSrcD = br; JumpD = jp;
        PCBranchD = tb; PCJumpD = tj; ImemReady = rdy;
    endtask

    typedef struct {
        logic        sf, sd, br, jp;
        logic [31:0] tb, tj;
        logic        rdy;
        logic [31:0] e_pcf;
        logic        e_req, e_busy, e_valid;
        logic [31:0] e_instr, e_pc4;
    } vec_t;

    vec_t tbl[13];

    // reference model state
    bit          m_started, m_hold, m_pend, m_valid;
    logic [31:0] m_pc, m_buf, m_pend_tgt, m_instr, m_pc4, m_rc, m_wc;

    task automatic model_reset();
        m_started = 0; m_hold = 0; m_pend = 0; m_valid = 0;
        m_pc = 0; m_buf = 0; m_pend_tgt = 0; m_instr = NOP; m_pc4 = 0; m_rc = 0; m_wc = 0;
    endtask

    task automatic model_step();
        bit          redir, req;
        logic [31:0] tgt, word;
        redir = (PCSrcD || JumpD) && !StallD;
        tgt   = (PCSrcD ? PCBranchD : PCJumpD) & ~32'd3;
        req   = m_started && !m_hold;
        word  = m_pc ^ K;
        if (redir) m_rc++;
        if (req && !ImemReady) m_wc++;
        if (!StallD) begin
            if (redir) begin
                m_instr = NOP; m_valid = 0; m_pc4 = 0;
            end else if (req && ImemReady && !m_pend && !StallF) begin
                m_instr = word; m_valid = 1; m_pc4 = m_pc + 4;
            end else if (m_hold && !StallF) begin
                m_instr = m_buf; m_valid = 1; m_pc4 = m_pc + 4;
            end else begin
                m_instr = NOP; m_valid = 0; m_pc4 = 0;
            end
        end
        if (!m_started) begin
            m_started = 1;
        end else if (m_hold) begin
            if (redir) begin
                m_pc = tgt; m_hold = 0;
            end else if (!StallF && !StallD) begin
                m_pc = m_pc + 4; m_hold = 0;
            end
        end else if (ImemReady) begin
            if (redir) begin
                m_pc = tgt; m_pend = 0;
            end else if (m_pend) begin
                m_pc = m_pend_tgt; m_pend = 0;
            end else if (StallF || StallD) begin
                m_hold = 1; m_buf = word;
            end else begin
                m_pc = m_pc + 4;
            end
        end else if (redir) begin
            m_pend = 1; m_pend_tgt = tgt;
        end
    endtask

    initial begin
        //          sf sd br jp tb          tj          rdy pcf         req busy vld instr          pc4
        tbl[0]  = '{0, 0, 0, 0, 32'h0,      32'h0,      1, 32'h0,      0, 0, 0, NOP,           32'h0};
        tbl[1]  = '{0, 0, 0, 0, 32'h0,      32'h0,      1, 32'h0,      1, 0, 0, NOP,           32'h0};
        tbl[2]  = '{0, 0, 0, 0, 32'h0,      32'h0,      1, 32'h4,      1, 0, 1, 32'h5A5A_1234, 32'h4};
        tbl[3]  = '{0, 0, 1, 0, 32'h100,    32'h0,      1, 32'h8,      1, 0, 1, 32'h5A5A_1230, 32'h8};
        tbl[4]  = '{0, 0, 0, 0, 32'h0,      32'h0,      1, 32'h100,    1, 0, 0, NOP,           32'h0};
        tbl[5]  = '{0, 1, 1, 0, 32'h300,    32'h0,      1, 32'h104,    1, 0, 1, 32'h5A5A_1334, 32'h104};
        tbl[6]  = '{1, 1, 0, 0, 32'h0,      32'h0,      0, 32'h104,    0, 0, 1, 32'h5A5A_1334, 32'h104};
        tbl[7]  = '{0, 0, 0, 0, 32'h0,      32'h0,      0, 32'h104,    0, 0, 1, 32'h5A5A_1334, 32'h104};
        tbl[8]  = '{0, 0, 0, 1, 32'h0,      32'h203,    0, 32'h108,    1, 1, 1, 32'h5A5A_1330, 32'h108};
        tbl[9]  = '{0, 0, 0, 0, 32'h0,      32'h0,      0, 32'h108,    1, 1, 0, NOP,           32'h0};
        tbl[10] = '{0, 0, 0, 0, 32'h0,      32'h0,      1, 32'h108,    1, 0, 0, NOP,           32'h0};
        tbl[11] = '{0, 0, 0, 0, 32'h0,      32'h0,      1, 32'h200,    1, 0, 0, NOP,           32'h0};
        tbl[12] = '{0, 0, 0, 0, 32'h0,      32'h0,      1, 32'h204,    1, 0, 1, 32'h5A5A_1034, 32'h204};

        // reset state
        #2;
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_req", {31'd0, ImemReq}, 32'd0);
        chk("rst_valid", {31'd0, ValidD}, 32'd0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pc4", PCPlus4D, 32'h0);
        chk("rst_busy", {31'd0, FetchBusy}, 32'd0);
        chk("rst_rcnt", RedirectCount, 32'd0);
        chk("rst_wcnt", ImemWaitCount, 32'd0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 13; i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].sf, tbl[i].sd, tbl[i].br, tbl[i].jp, tbl[i].tb, tbl[i].tj, tbl[i].rdy);
            #1;
            chk($sformatf("tbl%0d_pcf", i), PCF, tbl[i].e_pcf);
            chk($sformatf("tbl%0d_addr", i), ImemAddr, tbl[i].e_pcf);
            chk($sformatf("tbl%0d_req", i), {31'd0, ImemReq}, {31'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d_busy", i), {31'd0, FetchBusy}, {31'd0, tbl[i].e_busy});
            chk($sformatf("tbl%0d_valid", i), {31'd0, ValidD}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_instr", i), InstrD, tbl[i].e_instr);
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_pc4", i), PCPlus4D, tbl[i].e_pc4);
        end

        // PC wrap at the top of the address space
        @(negedge clk); drive(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1); #1;
        chk("wrap_pcf_top", PCF, 32'hFFFF_FFFC);
        chk("wrap_valid0", {31'd0, ValidD}, 32'd0);
        @(negedge clk); drive(0, 0, 0, 1, 0, 32'h80, 1); #1;
        chk("wrap_pcf0", PCF, 32'h0);
        chk("wrap_valid1", {31'd0, ValidD}, 32'd1);
        chk("wrap_instr", InstrD, 32'hFFFF_FFFC ^ K);
        chk("wrap_pc4", PCPlus4D, 32'h0);

        // reset mid-request, then a stray ready in IDLE must be ignored
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
        chk("mid_pcf", PCF, 32'h80);
        chk("mid_busy", {31'd0, FetchBusy}, 32'd1);
        #2 rst_n = 0; #1;
        chk("arst_pcf", PCF, 32'h0);
        chk("arst_req", {31'd0, ImemReq}, 32'd0);
        chk("arst_valid", {31'd0, ValidD}, 32'd0);
        @(negedge clk); rst_n = 1; drive(0, 0, 0, 0, 0, 0, 1); #1;
        chk("idle_req", {31'd0, ImemReq}, 32'd0);
        chk("idle_busy", {31'd0, FetchBusy}, 32'd0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
        chk("idle_ign_valid", {31'd0, ValidD}, 32'd0);
        chk("idle_ign_pcf", PCF, 32'h0);
        chk("idle_ign_req", {31'd0, ImemReq}, 32'd1);

        // randomized run against the reference model
        @(negedge clk); rst_n = 0; model_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic [31:0] exp_rc, exp_wc;
            @(negedge clk);
            rst_n = 1;
            drive(($urandom % 5) == 0, ($urandom % 6) == 0, ($urandom % 9) == 0, ($urandom % 9) == 0,
                  $urandom, $urandom, ($urandom % 3) != 0);
            #1;
`ifdef FETCH_PERF_CNT_EN
            exp_rc = m_rc; exp_wc = m_wc;
`else
            exp_rc = 0; exp_wc = 0;
`endif
            chk("rnd_pcf", PCF, m_pc);
            chk("rnd_addr", ImemAddr, m_pc);
            chk("rnd_req", {31'd0, ImemReq}, {31'd0, m_started && !m_hold});
            chk("rnd_busy", {31'd0, FetchBusy}, {31'd0, m_started && !m_hold && !ImemReady});
            chk("rnd_valid", {31'd0, ValidD}, {31'd0, m_valid});
            chk("rnd_instr", InstrD, m_instr);
            if (m_valid) chk("rnd_pc4", PCPlus4D, m_pc4);
            chk("rnd_rcnt", RedirectCount, exp_rc);
            chk("rnd_wcnt", ImemWaitCount, exp_wc);
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
